rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register data width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, the single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- req0_valid, in, 1, ALU write-back request.
- req0_addr, in, ADDR_WIDTH, destination register for req0.
- req0_data, in, DATA_WIDTH, write data for req0.
- req0_ready, out, 1, req0 accepted this cycle.
- req1_valid, in, 1, LSU write-back request.
- req1_addr, in, ADDR_WIDTH, destination register for req1.
- req1_data, in, DATA_WIDTH, write data for req1.
- req1_ready, out, 1, req1 accepted this cycle.
- mark_valid, in, 1, issue stage reserves a destination register.
- mark_addr, in, ADDR_WIDTH, register to reserve.
- query_addr, in, ADDR_WIDTH, register to check for a pending write.
- query_busy, out, 1, the queried register has a pending write.
- pending_cnt, out, ADDR_WIDTH+1, number of reserved registers.
- rf_wen, out, 1, register-file write enable.
- rf_waddr, out, ADDR_WIDTH, register-file write address.
- rf_wdata, out, DATA_WIDTH, register-file write data.

Function
REQ-003 A request SHALL be accepted when reqN_valid and reqN_ready are both high on a rising clk edge.
REQ-004 A requester SHALL hold valid, addr and data stable until accepted; the block SHALL NOT check this.
REQ-005 reqN_ready SHALL be combinational from the valids and the round-robin pointer.
REQ-006 At most one ready SHALL be high per cycle.
REQ-007 A ready SHALL never be high while its own valid is low.
REQ-008 With exactly one valid high, that requester SHALL be granted.
REQ-009 With both valids high, the requester not granted most recently SHALL be granted.
REQ-010 The round-robin pointer SHALL update only on a grant and SHALL record the granted requester.
REQ-011 An accepted request SHALL appear on rf_waddr/rf_wdata in the next cycle (1-cycle latency).
REQ-012 rf_wen SHALL be high for exactly that one cycle when the accepted addr is nonzero.
REQ-013 With no acceptance, rf_wen SHALL be 0 next cycle; rf_waddr and rf_wdata SHALL hold their last values.
REQ-014 An accepted write to register 0 SHALL complete its handshake with rf_wen=0.
REQ-015 The pending scoreboard SHALL have 2**ADDR_WIDTH busy bits.
REQ-016 mark_valid SHALL set busy[mark_addr] at the clock edge; mark_addr=0 SHALL be ignored.
REQ-017 The edge ending a cycle with rf_wen=1 SHALL clear busy[rf_waddr].
REQ-018 A set and a clear of the same address at the same edge SHALL leave the bit set (new producer wins).
REQ-019 A set of an already-busy bit SHALL keep it set, with no count change.
REQ-020 A clear of an idle bit SHALL be a no-op.
REQ-021 query_busy SHALL equal busy[query_addr], combinationally; query_addr=0 SHALL always return 0.
REQ-022 pending_cnt SHALL equal the population count of the busy bits, registered and updated at the same edge as the bits.
REQ-023 pending_cnt SHALL never wrap: its maximum is 2**ADDR_WIDTH-1, since bit 0 never sets.
REQ-024 Register 0 SHALL never be busy.

Reset
REQ-025 On reset high, asynchronously:
- rf_wen=0, rf_waddr=0, rf_wdata=0.
- All busy bits cleared; pending_cnt=0.
- Pointer set so req0 wins the first contention.
REQ-026 During reset, both readys and query_busy SHALL be 0.
REQ-027 Reset mid-operation SHALL discard any accepted-but-unwritten request; rf_wen SHALL NOT pulse after reset releases.
REQ-028 Normal operation SHALL start at the first rising clk edge after reset deasserts.

Verification
REQ-029 Reset released; req0 (addr 3, data 0xA5) and req1 (addr 4, data 0x5A) held valid together:
- Cycle 0: req0_ready=1.
- Cycle 1: rf_wen=1, rf_waddr=3, rf_wdata=0xA5; req1_ready=1.
- Cycle 2: rf_wen=1, rf_waddr=4, rf_wdata=0x5A.
REQ-030 Both requesters continuously valid for 6 cycles: grants SHALL alternate 0,1,0,1,0,1, with rf_wen=1 on every following cycle.
REQ-031 Only req1 valid, addr 0, data 0xFF: req1_ready=1; next cycle rf_wen=0; pending_cnt unchanged.
REQ-032 Scoreboard sequence:
- mark addr 7: next cycle query_busy(7)=1, pending_cnt=1.
- req0 write to 7 accepted: rf_wen=1 next cycle.
- Cycle after rf_wen: query_busy(7)=0, pending_cnt=0.
REQ-033 mark addr 9 in the same cycle that rf_wen=1 with rf_waddr=9: busy[9] SHALL stay 1 and pending_cnt SHALL be unchanged.
REQ-034 Assert reset in the cycle after req0 is accepted: rf_wen SHALL be 0 throughout and after reset; pending_cnt=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Two-requester register-file write-back arbiter with a pending-write scoreboard.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   req0_valid/addr/data/ready  ALU write-back request channel (valid/ready handshake)
//   req1_valid/addr/data/ready  LSU write-back request channel (valid/ready handshake)
//   mark_valid, mark_addr       issue stage reserves a destination register
//   query_addr, query_busy      combinational lookup of a register's pending state
//   pending_cnt                 registered count of reserved registers
//   rf_wen, rf_waddr, rf_wdata  registered register-file write port (1-cycle latency)
//
// Arbitration is round-robin between the two requesters. Writes to register 0
// complete the handshake but never raise rf_wen, and register 0 is never busy.

module rf_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  mark_valid,
    input  logic [ADDR_WIDTH-1:0] mark_addr,
    input  logic [ADDR_WIDTH-1:0] query_addr,
    output logic                  query_busy,
    output logic [ADDR_WIDTH:0]   pending_cnt,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam int CW   = ADDR_WIDTH + 1;

    // Population count of the busy vector; the result fits in ADDR_WIDTH+1 bits.
    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] vec);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // r_last_grant: 1'b1 = req1 was granted most recently, 1'b0 = req0.
    logic                  r_last_grant;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NREG-1:0]       r_busy;
    logic [CW-1:0]         r_pending;

    logic                  w_grant0;
    logic                  w_grant1;
    logic [NREG-1:0]       w_set_vec;
    logic [NREG-1:0]       w_clr_vec;
    logic [NREG-1:0]       w_busy_next;

    // Round-robin grant: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset) begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end else begin
            w_grant0 = req0_valid && (!req1_valid || r_last_grant);
            w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Pointer records the most recent grant; reset favours req0 at first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Write port register: capture the granted request; address/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_waddr <= {ADDR_WIDTH{1'b0}};
            r_wdata <= {DATA_WIDTH{1'b0}};
        end else if (w_grant0) begin
            r_wen   <= (req0_addr != {ADDR_WIDTH{1'b0}});
            r_waddr <= req0_addr;
            r_wdata <= req0_data;
        end else if (w_grant1) begin
            r_wen   <= (req1_addr != {ADDR_WIDTH{1'b0}});
            r_waddr <= req1_addr;
            r_wdata <= req1_data;
        end else begin
            r_wen   <= 1'b0;
            r_waddr <= r_waddr;
            r_wdata <= r_wdata;
        end
    end

    // Scoreboard next state: set applied after clear so a new producer wins a same-edge
    // collision; bit 0 is forced clear so register 0 can never be reserved.
    always_comb begin
        w_set_vec = {NREG{1'b0}};
        w_clr_vec = {NREG{1'b0}};
        if (mark_valid && (mark_addr != {ADDR_WIDTH{1'b0}})) begin
            w_set_vec[mark_addr] = 1'b1;
        end else begin
            w_set_vec = {NREG{1'b0}};
        end
        if (r_wen) begin
            w_clr_vec[r_waddr] = 1'b1;
        end else begin
            w_clr_vec = {NREG{1'b0}};
        end
        w_busy_next    = (r_busy & ~w_clr_vec) | w_set_vec;
        w_busy_next[0] = 1'b0;
    end

    // Busy bits and their count update together so pending_cnt always matches the bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= {NREG{1'b0}};
            r_pending <= {CW{1'b0}};
        end else begin
            r_busy    <= w_busy_next;
            r_pending <= popcount(w_busy_next);
        end
    end

    assign query_busy  = !reset && (query_addr != {ADDR_WIDTH{1'b0}}) && r_busy[query_addr];
    assign pending_cnt = r_pending;
    assign rf_wen      = r_wen;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          mark_valid = 1'b0;
    logic [AW-1:0] mark_addr = '0;
    logic [AW-1:0] query_addr = '0;
    logic          query_busy;
    logic [AW:0]   pending_cnt;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    rf_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .query_addr(query_addr), .query_busy(query_busy), .pending_cnt(pending_cnt),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: set of reserved registers, who was granted last, and the write port.
    bit          m_busy [32];
    int          m_last;
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_busy[i];
        return c;
    endfunction

    // Which requester should be granted now (-1 = none).
    function automatic int expected_grant();
        if (reset) return -1;
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_last  = 1;
        m_wen   = 1'b0;
        m_waddr = 0;
        m_wdata = 32'h0;
    endtask

    // One clock cycle: entered just after a rising edge with inputs set; leaves at edge+1.
    task automatic cycle(output int g);
        int eg;
        #1;
        eg = expected_grant();
        check("req0_ready", req0_ready, eg == 0);
        check("req1_ready", req1_ready, eg == 1);
        check("query_busy", query_busy, (query_addr != 0) && m_busy[query_addr]);
        g = req0_ready ? 0 : (req1_ready ? 1 : -1);
        @(posedge clk);
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (mark_valid && mark_addr != 0) m_busy[mark_addr] = 1'b1;
        if (eg == 0) begin
            m_waddr = req0_addr; m_wdata = req0_data; m_wen = (req0_addr != 0); m_last = 0;
        end else if (eg == 1) begin
            m_waddr = req1_addr; m_wdata = req1_data; m_wen = (req1_addr != 0); m_last = 1;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        check("rf_wen", rf_wen, m_wen);
        check("rf_waddr", rf_waddr, m_waddr);
        check("rf_wdata", rf_wdata, m_wdata);
        check("pending_cnt", pending_cnt, model_count());
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        mark_valid = 1'b0; mark_addr = '0; query_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wen", rf_wen, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 32'h0);
        check("rst_cnt", pending_cnt, 6'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        model_reset();

        // Contention after reset: req0 first, then req1.
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA5;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h5A;
        cycle(g);
        check("t29_grant0", g, 0);
        req0_valid = 1'b0;
        check("t29_wen1", rf_wen, 1'b1);
        check("t29_waddr1", rf_waddr, 5'd3);
        check("t29_wdata1", rf_wdata, 32'hA5);
        cycle(g);
        check("t29_grant1", g, 1);
        req1_valid = 1'b0;
        check("t29_wen2", rf_wen, 1'b1);
        check("t29_waddr2", rf_waddr, 5'd4);
        check("t29_wdata2", rf_wdata, 32'h5A);
        cycle(g);
        check("t29_idle_wen", rf_wen, 1'b0);

        // Continuous contention alternates.
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1111;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h2222;
        for (int i = 0; i < 6; i++) begin
            cycle(g);
            check("t30_alt", g, i % 2);
            check("t30_wen", rf_wen, 1'b1);
        end
        clear_inputs();
        cycle(g);

        // Write to register 0 completes with no rf_wen and no count change.
        mark_valid = 1'b1; mark_addr = 5'd12;
        cycle(g);
        mark_valid = 1'b0;
        check("t31_cnt_before", pending_cnt, 6'd1);
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
        cycle(g);
        check("t31_grant", g, 1);
        req1_valid = 1'b0;
        check("t31_wen", rf_wen, 1'b0);
        check("t31_cnt", pending_cnt, 6'd1);

        // Scoreboard set then clear by write-back.
        do_reset();
        mark_valid = 1'b1; mark_addr = 5'd7;
        cycle(g);
        mark_valid = 1'b0; query_addr = 5'd7;
        #1;
        check("t32_busy", query_busy, 1'b1);
        check("t32_cnt1", pending_cnt, 6'd1);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hCAFE;
        cycle(g);
        req0_valid = 1'b0;
        check("t32_wen", rf_wen, 1'b1);
        cycle(g);
        check("t32_cnt0", pending_cnt, 6'd0);
        #1;
        check("t32_idle", query_busy, 1'b0);

        // Set and clear of the same register at one edge: set wins.
        mark_valid = 1'b1; mark_addr = 5'd9;
        cycle(g);
        mark_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hBEEF;
        cycle(g);
        req0_valid = 1'b0;
        check("t33_wen", rf_wen, 1'b1);
        mark_valid = 1'b1; mark_addr = 5'd9; query_addr = 5'd9;
        cycle(g);
        mark_valid = 1'b0;
        check("t33_cnt", pending_cnt, 6'd1);
        #1;
        check("t33_busy", query_busy, 1'b1);

        // Reset mid-operation discards the write and clears the scoreboard.
        do_reset();
        mark_valid = 1'b1; mark_addr = 5'd10;
        cycle(g);
        mark_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd11; req0_data = 32'h77;
        query_addr = 5'd10;
        cycle(g);
        #1;
        reset = 1'b1;
        #1;
        check("t34_wen_rst", rf_wen, 1'b0);
        check("t34_cnt_rst", pending_cnt, 6'd0);
        check("t34_rdy_rst", req0_ready, 1'b0);
        check("t34_q_rst", query_busy, 1'b0);
        @(posedge clk);
        #1;
        check("t34_wen_rst2", rf_wen, 1'b0);
        reset = 1'b0;
        model_reset();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            check("t34_wen_after", rf_wen, 1'b0);
        end

        // Randomized traffic; requesters hold their request until accepted.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1;
                req0_addr  = 5'($urandom_range(0, 15));
                req0_data  = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1;
                req1_addr  = 5'($urandom_range(0, 15));
                req1_data  = $urandom;
            end
            mark_valid = ($urandom_range(0, 2) == 0);
            mark_addr  = ($urandom_range(0, 3) == 0) ? 5'(m_waddr) : 5'($urandom_range(0, 31));
            query_addr = 5'($urandom_range(0, 31));
            cycle(g);
            if (g == 0) req0_valid = 1'b0;
            if (g == 1) req1_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
